// File: rtl/sincos_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sincos_seq
//  Description : Sequential sine/cosine evaluator in sign-magnitude fixed
//                point. Folds a full-range angle to a quarter turn, then runs
//                a 7th-order odd polynomial by Horner's rule on one shared
//                multiplier, first for sin and then for cos.
//  Revision    : 1.0 - initial release
// ============================================================================
module sincos_seq #(
   parameter int N = 24,   // total word width including the sign bit
   parameter int Q = 12    // fractional bits
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [N-1:0] i_angle,
   output logic         o_busy,
   output logic         o_valid,
   output logic [N-1:0] o_sin,
   output logic [N-1:0] o_cos
);

   // Magnitude width (everything except the sign bit)
   localparam int c_M = N - 1;

   // Polynomial and folding constants, floor(c * 2^Q), evaluated at elaboration
   localparam real c_PI      = 3.14159265358979323846;
   localparam real c_HALF_PI = c_PI / 2.0;
   localparam real c_SCALE   = 2.0 ** Q;

   localparam logic [c_M-1:0] c_K   = c_M'($rtoi(2.0 / c_PI * c_SCALE));
   localparam logic [c_M-1:0] c_C1  = c_M'($rtoi(c_HALF_PI * c_SCALE));
   localparam logic [c_M-1:0] c_C3  = c_M'($rtoi((c_HALF_PI ** 3) / 6.0 * c_SCALE));
   localparam logic [c_M-1:0] c_C5  = c_M'($rtoi((c_HALF_PI ** 5) / 120.0 * c_SCALE));
   localparam logic [c_M-1:0] c_C7  = c_M'($rtoi((c_HALF_PI ** 7) / 5040.0 * c_SCALE));
   localparam logic [c_M-1:0] c_ONE = c_M'(1) << Q;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RANGE  = 3'd1,
      S_EVAL_S = 3'd2,
      S_EVAL_C = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Working registers
   logic [N-1:0]     r_angle;
   logic [c_M-1:0]   r_fs;
   logic [c_M-1:0]   r_fc;
   logic             r_ss;
   logic             r_sc;
   logic [c_M-1:0]   r_x2;
   logic [c_M-1:0]   r_h;
   logic [c_M-1:0]   r_sin_mag;
   logic [c_M-1:0]   r_cos_mag;
   logic [2:0]       r_step;

   // Output registers
   logic             r_busy;
   logic             r_valid;
   logic [N-1:0]     r_sin;
   logic [N-1:0]     r_cos;

   // Datapath wires
   logic [c_M-1:0]   w_x;
   logic [c_M-1:0]   w_mul_a;
   logic [c_M-1:0]   w_mul_b;
   logic [c_M-1:0]   w_base;
   logic [2*c_M-1:0] w_prod;
   logic [c_M-1:0]   w_mul;
   logic [c_M-1:0]   w_sub;
   logic [c_M-1:0]   w_res;
   logic [1:0]       w_q;
   logic [1:0]       w_qc;
   logic [c_M-1:0]   w_f;
   logic [c_M-1:0]   w_fs;
   logic [c_M-1:0]   w_fc;
   logic             w_last;

   assign w_last = (r_step == 3'd4);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: a fixed sequence once a request is accepted
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_state_nxt = S_RANGE;
         S_RANGE:  w_state_nxt = S_EVAL_S;
         S_EVAL_S: if (w_last) w_state_nxt = S_EVAL_C;
         S_EVAL_C: if (w_last) w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Operand selection for the single shared multiplier and the Horner subtract
   always_comb begin
      w_x     = (r_state == S_EVAL_C) ? r_fc : r_fs;
      w_mul_a = '0;
      w_mul_b = '0;
      w_base  = '0;
      if (r_state == S_RANGE) begin
         w_mul_a = r_angle[c_M-1:0];
         w_mul_b = c_K;
      end else if ((r_state == S_EVAL_S) || (r_state == S_EVAL_C)) begin
         case (r_step)
            3'd0: begin
               w_mul_a = w_x;
               w_mul_b = w_x;
            end
            3'd1: begin
               w_mul_a = r_x2;
               w_mul_b = c_C7;
               w_base  = c_C5;
            end
            3'd2: begin
               w_mul_a = r_x2;
               w_mul_b = r_h;
               w_base  = c_C3;
            end
            3'd3: begin
               w_mul_a = r_x2;
               w_mul_b = r_h;
               w_base  = c_C1;
            end
            default: begin
               w_mul_a = w_x;
               w_mul_b = r_h;
            end
         endcase
      end
   end

   // Fixed-point multiply: (a*b) >> Q, truncated to the magnitude width
   assign w_prod = {{c_M{1'b0}}, w_mul_a} * {{c_M{1'b0}}, w_mul_b};
   assign w_mul  = c_M'(w_prod >> Q);

   // Horner step; the operand ordering guarantees no underflow
   assign w_sub  = w_base - w_mul;

   // Final magnitude never exceeds 1.0
   assign w_res  = (w_mul > c_ONE) ? c_ONE : w_mul;

   // Quadrant folding from the scaled angle; bits above Q+1 wrap away
   assign w_q    = w_mul[Q+1:Q];
   assign w_qc   = w_q + 2'd1;
   assign w_f    = {{(c_M-Q){1'b0}}, w_mul[Q-1:0]};
   assign w_fs   = w_q[0]  ? (c_ONE - w_f) : w_f;
   assign w_fc   = w_qc[0] ? (c_ONE - w_f) : w_f;

   // Datapath and output registers, advanced by the current state
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_angle   <= '0;
         r_fs      <= '0;
         r_fc      <= '0;
         r_ss      <= 1'b0;
         r_sc      <= 1'b0;
         r_x2      <= '0;
         r_h       <= '0;
         r_sin_mag <= '0;
         r_cos_mag <= '0;
         r_step    <= '0;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_sin     <= '0;
         r_cos     <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_angle <= i_angle;
                  r_busy  <= 1'b1;
               end
            end
            S_RANGE: begin
               r_fs   <= w_fs;
               r_fc   <= w_fc;
               r_ss   <= r_angle[N-1] ^ w_q[1];
               r_sc   <= w_qc[1];
               r_step <= '0;
            end
            S_EVAL_S, S_EVAL_C: begin
               case (r_step)
                  3'd0:             r_x2 <= w_mul;
                  3'd1, 3'd2, 3'd3: r_h  <= w_sub;
                  default: begin
                     if (r_state == S_EVAL_S) begin
                        r_sin_mag <= w_res;
                     end else begin
                        r_cos_mag <= w_res;
                     end
                  end
               endcase
               r_step <= w_last ? 3'd0 : (r_step + 3'd1);
            end
            S_DONE: begin
               // A zero magnitude is always reported with a positive sign
               r_sin   <= {r_ss & (r_sin_mag != '0), r_sin_mag};
               r_cos   <= {r_sc & (r_cos_mag != '0), r_cos_mag};
               r_valid <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy  = r_busy;
   assign o_valid = r_valid;
   assign o_sin   = r_sin;
   assign o_cos   = r_cos;

endmodule
`default_nettype wire

// File: tb/tb_sincos_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sincos_seq
//  Description : Self-checking bench for sincos_seq with a behavioural
//                arithmetic model, a per-cycle compare process and directed
//                literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sincos_seq;

   localparam int N = 24;
   localparam int Q = 12;

   // Constants for Q=12, written out as literals
   localparam longint c_K   = 2607;
   localparam longint c_C1  = 6433;
   localparam longint c_C3  = 2645;
   localparam longint c_C5  = 326;
   localparam longint c_C7  = 19;
   localparam longint c_ONE = 4096;
   localparam longint c_MSK = (longint'(1) << (N-1)) - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [N-1:0] angle;
   logic         busy;
   logic         valid;
   logic [N-1:0] sin_o;
   logic [N-1:0] cos_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sincos_seq #(.N(N), .Q(Q)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .i_angle (angle),
      .o_busy  (busy),
      .o_valid (valid),
      .o_sin   (sin_o),
      .o_cos   (cos_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_near(input string name, input longint act, input longint exp, input longint tol);
      longint d;
      checks++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic longint mulq(input longint a, input longint b);
      return ((a * b) >> Q) & c_MSK;
   endfunction

   // sin(pi/2 * x/2^Q) * 2^Q by the odd polynomial, clamped to 1.0
   function automatic longint poly(input longint x);
      longint x2, h, r;
      x2 = mulq(x, x);
      h  = c_C5 - mulq(x2, c_C7);
      h  = c_C3 - mulq(x2, h);
      h  = c_C1 - mulq(x2, h);
      r  = mulq(x, h);
      if (r > c_ONE) r = c_ONE;
      return r;
   endfunction

   function automatic logic [N-1:0] pack(input bit sgn, input longint mag);
      logic [N-1:0] v;
      v = N'(mag);
      v[N-1] = sgn && (mag != 0);
      return v;
   endfunction

   function automatic void model(input logic [N-1:0] a, output logic [N-1:0] s, output logic [N-1:0] c);
      longint y, f, fs, fc;
      int quad, qc;
      y    = mulq(longint'(a[N-2:0]), c_K);
      quad = int'((y >> Q) % 4);
      f    = y % c_ONE;
      qc   = (quad + 1) % 4;
      fs   = (quad % 2 == 1) ? (c_ONE - f) : f;
      fc   = (qc % 2 == 1) ? (c_ONE - f) : f;
      s    = pack(a[N-1] ^ (quad >= 2), poly(fs));
      c    = pack(qc >= 2, poly(fc));
   endfunction

   // ---------------- compare process ----------------
   int           k = 0;
   bit           pend = 1'b0;
   int           acc_k = 0;
   logic [N-1:0] hold_s = '0;
   logic [N-1:0] hold_c = '0;
   logic [N-1:0] pend_s = '0;
   logic [N-1:0] pend_c = '0;
   bit           exp_valid;
   bit           exp_busy;

   // Per-cycle check of every output against the model's request timeline
   always @(negedge clk) begin
      k++;
      if (!rst_n) begin
         pend   = 1'b0;
         hold_s = '0;
         hold_c = '0;
         check("rst_busy",  busy,  0);
         check("rst_valid", valid, 0);
         check("rst_sin",   sin_o, 0);
         check("rst_cos",   cos_o, 0);
      end else begin
         exp_valid = pend && (k == acc_k + 13);
         exp_busy  = pend && (k > acc_k) && (k <= acc_k + 12);
         if (exp_valid) begin
            hold_s = pend_s;
            hold_c = pend_c;
            pend   = 1'b0;
         end
         check("cyc_valid", valid, exp_valid);
         check("cyc_busy",  busy,  exp_busy);
         check("cyc_sin",   sin_o, hold_s);
         check("cyc_cos",   cos_o, hold_c);
         if (start && !pend) begin
            pend  = 1'b1;
            acc_k = k;
            model(angle, pend_s, pend_c);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_one(input logic [N-1:0] a, output logic [N-1:0] s, output logic [N-1:0] c);
      bit got;
      got = 1'b0;
      @(posedge clk);
      #2;
      start = 1'b1;
      angle = a;
      @(posedge clk);
      #2;
      start = 1'b0;
      angle = N'($urandom);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (valid) begin
            got = 1'b1;
            break;
         end
      end
      check("result_arrives", got, 1);
      s = sin_o;
      c = cos_o;
   endtask

   logic [N-1:0] s;
   logic [N-1:0] c;
   logic [N-1:0] ms;
   logic [N-1:0] mc;
   int           nv;
   int           vt[4];

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      angle = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Model pinned by hand-derived values
      model(24'd38603, ms, mc);
      check("model_3pi_sin", ms, 24'd10);
      check("model_3pi_cos", mc, 24'h800FFE);

      // angle = 0
      run_one(24'd0, s, c);
      check("a0_sin", s, 24'd0);
      check("a0_cos", c, 24'd4095);

      // negative zero angle: sin magnitude zero must carry a positive sign
      run_one(24'h800000, s, c);
      check("negzero_sin", s, 24'd0);
      check("negzero_cos", c, 24'd4095);

      // pi/6
      run_one(24'd2145, s, c);
      check("pi6_sin_sign", s[N-1], 0);
      check_near("pi6_sin", longint'(s[N-2:0]), 2048, 8);
      check("pi6_cos_sign", c[N-1], 0);
      check_near("pi6_cos", longint'(c[N-2:0]), 3547, 8);

      // -pi/2
      run_one({1'b1, 23'd6434}, s, c);
      check("mpi2_sin_sign", s[N-1], 1);
      check_near("mpi2_sin", longint'(s[N-2:0]), 4096, 8);
      check_near("mpi2_cos", longint'(c[N-2:0]), 0, 8);

      // 3*pi: quadrant wrap; the small residual comes from the truncated 2/pi
      run_one(24'd38603, s, c);
      check("3pi_sin", s, 24'd10);
      check("3pi_cos", c, 24'h800FFE);

      // asynchronous reset in the middle of EVAL_S
      @(posedge clk);
      #2;
      start = 1'b1;
      angle = 24'd2145;
      @(posedge clk);
      #2;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy",  busy,  0);
      check("midrst_valid", valid, 0);
      check("midrst_sin",   sin_o, 0);
      check("midrst_cos",   cos_o, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      run_one(24'd2145, s, c);
      check_near("postrst_sin", longint'(s[N-2:0]), 2048, 8);
      check_near("postrst_cos", longint'(c[N-2:0]), 3547, 8);

      // start held high for 40 cycles with a sweeping angle
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #2;
         start = 1'b1;
         angle = N'(1000 + i * 977);
         @(negedge clk);
         if (valid) begin
            if (nv < 4) vt[nv] = i;
            nv++;
         end
      end
      @(posedge clk);
      #2 start = 1'b0;
      check("b2b_count", nv, 3);
      if (nv >= 3) begin
         check("b2b_gap1", vt[1] - vt[0], 13);
         check("b2b_gap2", vt[2] - vt[1], 13);
      end
      repeat (16) @(posedge clk);

      // random requests, including strobes while busy
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #2;
         start = ($urandom_range(0, 3) == 0);
         angle = N'($urandom);
      end
      @(posedge clk);
      #2 start = 1'b0;
      repeat (16) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
